avalon_gpio_pio: RTL and testbench
==================================

Name: avalon_gpio_pio

Overview:
Parametrised Avalon-MM slave GPIO port. It is the bidirectional, interrupt-capable successor to the team's 8-bit output-only PIO.
- Per-bit direction control.
- Atomic set/clear of output bits.
- Synchronised inputs.
- Edge capture and a maskable level interrupt to the Nios II.
- Sits on the CPU data master via the Qsys interconnect; pins go to LEDs, switches and keys.

Parameters:
WIDTH, 8, number of GPIO bits (1..32)
OUT_RESET, 0, reset value of output data register (WIDTH bits)
DIR_RESET, 0, reset value of direction register (1 = output)
EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any
SYNC_STAGES, 2, input synchroniser depth (2..3)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data (bits above WIDTH ignored)
readdata  out  32  read data, zero-extended above WIDTH
gpio_in  in  WIDTH  asynchronous pin inputs
gpio_out  out  WIDTH  output data register
gpio_oe  out  WIDTH  output enable (= direction register)
irq  out  1  level interrupt, active high

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-low (reset_n); all registers clear on the falling edge of reset_n, independent of clk.
- Reset values:
  - data_out = OUT_RESET; direction = DIR_RESET.
  - irq_mask = 0; edge_cap = 0; synchroniser flops = 0; prev-sample flop = 0.
  - irq = 0.
- Write strobe: wr = chipselect & ~write_n. Reads have zero wait states and zero read latency: readdata is combinational from address and register state.
- Register map (word address):
  - 0 DATA: write loads data_out. Read returns (sync_in & ~dir) | (data_out & dir).
  - 1 DIR: read/write direction register.
  - 2 IRQMASK: read/write interrupt mask.
  - 3 EDGECAP: read returns edge_cap. Writing 1 to a bit clears it; 0 leaves it.
  - 4 OUTSET: write sets data_out bits where writedata = 1. Reads 0.
  - 5 OUTCLR: write clears data_out bits where writedata = 1. Reads 0.
  - 6, 7: reserved. Writes ignored; reads 0.
- Input path:
  - gpio_in passes through SYNC_STAGES flops to give sync_in.
  - prev holds sync_in delayed by one cycle.
  - Edge vector: rising = sync_in & ~prev; falling = ~sync_in & prev; any = sync_in ^ prev.
  - Latency from a pin change to the edge_cap bit set is SYNC_STAGES+1 clk edges.
- Edge capture applies to all bits regardless of direction. Output-direction bits still capture their own pin.
- Simultaneous EDGECAP clear-write and a new edge on the same bit in the same cycle: the set wins and the bit stays 1.
- irq = |(edge_cap & irq_mask), combinational from registers. It stays asserted until the bits are cleared or masked.
- gpio_out = data_out at all times, independent of direction. gpio_oe = direction. The tristate buffer lives at the top level.
- Writes take effect at the next clk edge and are visible on gpio_out and in readback the following cycle.
- Reset mid-operation: pending edges are discarded and irq drops immediately (asynchronous). After reset release, the synchroniser refills from 0, so a pin held high produces one rising edge SYNC_STAGES+1 cycles after reset.

Decomposition:
- Package avalon_gpio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3, ADDR_OUTSET=4, ADDR_OUTCLR=5;
  - edge-type constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- One sub-module, gpio_sync_edge: parametrised synchroniser plus edge detector. Inputs WIDTH, SYNC_STAGES, EDGE_TYPE; outputs sync_in and the edge vector.
- The top level holds the register file, the read mux and irq.

Test Plan:
1. Reset → gpio_out=0x00, gpio_oe=0x00, irq=0. Read addr 0 with gpio_in=0xA5 after 3 cycles → readdata=0x000000A5.
2. Write DIR=0x0F, DATA=0x3C, gpio_in=0xF0 → gpio_out=0x3C; read DATA = 0xFC, i.e. (0xF0&0xF0)|(0x3C&0x0F).
3. DATA=0x81, then OUTSET 0x06 → gpio_out=0x87; then OUTCLR 0x81 → gpio_out=0x06. Read of addr 4 or 5 → 0.
4. EDGE_TYPE=0, IRQMASK=0x01: gpio_in bit0 rises 0→1 → EDGECAP bit0=1 exactly SYNC_STAGES+1 cycles later, irq=1. Write EDGECAP=0x01 → irq=0 next cycle. A falling edge on bit0 → no capture.
5. EDGECAP clear-write to bit2 in the same cycle bit2's edge is detected → EDGECAP bit2 stays 1, irq remains asserted if masked in.
6. irq asserted, then reset_n pulsed low mid-cycle → irq and edge_cap go to 0 without a clk edge. DIR and DATA return to DIR_RESET and OUT_RESET (run with WIDTH=4, OUT_RESET=0x5: gpio_out=0x5).

Source files
------------

// File: rtl/avalon_gpio_pkg.sv
// Shared constants for the Avalon-MM GPIO port: register word addresses and
// edge-capture type selectors.
package avalon_gpio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-stage input synchroniser followed by a one-cycle-delayed compare that
// produces a per-bit edge pulse of the selected polarity.
module gpio_sync_edge
  import avalon_gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

  if (EDGE_TYPE == EDGE_RISE) begin : g_rise
    assign edge_o = sync_o & ~prev_q;
  end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
    assign edge_o = ~sync_o & prev_q;
  end else begin : g_any
    assign edge_o = sync_o ^ prev_q;
  end

endmodule

// File: rtl/avalon_gpio_pio.sv
// Avalon-MM GPIO slave: direction, data with atomic set/clear, edge capture
// and a maskable level interrupt. Zero-latency combinational readback.
module avalon_gpio_pio
  import avalon_gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] OUT_RESET   = '0,
  parameter logic [31:0] DIR_RESET   = '0,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] sync_in, edge_vec, wdata, rdata;
  logic             wr;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .gpio_i (gpio_in),
    .sync_o (sync_in),
    .edge_o (edge_vec)
  );

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q;
    if (wr) begin
      case (address)
        ADDR_DATA:    data_out_d = wdata;
        ADDR_DIR:     dir_d      = wdata;
        ADDR_IRQMASK: irq_mask_d = wdata;
        ADDR_EDGECAP: edge_cap_d = edge_cap_q & ~wdata;
        ADDR_OUTSET:  data_out_d = data_out_q | wdata;
        ADDR_OUTCLR:  data_out_d = data_out_q & ~wdata;
        default:      ;
      endcase
    end
    // A new edge overrides a same-cycle clear so no event is ever lost.
    edge_cap_d = edge_cap_d | edge_vec;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= OUT_RESET[WIDTH-1:0];
      dir_q      <= DIR_RESET[WIDTH-1:0];
      irq_mask_q <= '0;
      edge_cap_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (address)
      ADDR_DATA:    rdata = (sync_in & ~dir_q) | (data_out_q & dir_q);
      ADDR_DIR:     rdata = dir_q;
      ADDR_IRQMASK: rdata = irq_mask_q;
      ADDR_EDGECAP: rdata = edge_cap_q;
      default:      rdata = '0;
    endcase
  end

  assign readdata = 32'(rdata);
  assign gpio_out = data_out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_avalon_gpio_pio.sv
// Directed plus randomized bench for avalon_gpio_pio, checked against a
// pin-history reference model of the register file and edge capture.
module tb_avalon_gpio_pio;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out, gpio_oe;
  logic        irq;

  logic        cs4 = 1'b0;
  logic [3:0]  gpio_in4 = '0;
  logic [3:0]  gpio_out4, gpio_oe4;
  logic [31:0] readdata4;
  logic        irq4;

  int compared = 0;
  int mismatched = 0;

  // Reference state; hist[k] is the pin value sampled k edges ago.
  logic [7:0] m_out, m_dir, m_mask, m_cap;
  logic [7:0] hist [S+1];

  always #5 clk = ~clk;

  avalon_gpio_pio #(
    .WIDTH(8), .OUT_RESET(32'h0), .DIR_RESET(32'h0), .EDGE_TYPE(0), .SYNC_STAGES(S)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  avalon_gpio_pio #(
    .WIDTH(4), .OUT_RESET(32'h5), .DIR_RESET(32'h0), .EDGE_TYPE(0), .SYNC_STAGES(S)
  ) u_dut4 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs4),
    .write_n(write_n), .writedata(writedata), .readdata(readdata4), .gpio_in(gpio_in4),
    .gpio_out(gpio_out4), .gpio_oe(gpio_oe4), .irq(irq4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_out = 8'h00; m_dir = 8'h00; m_mask = 8'h00; m_cap = 8'h00;
    for (int i = 0; i <= S; i++) hist[i] = 8'h00;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {24'h0, (hist[S-1] & ~m_dir) | (m_out & m_dir)};
      3'd1:    return {24'h0, m_dir};
      3'd2:    return {24'h0, m_mask};
      3'd3:    return {24'h0, m_cap};
      default: return 32'h0;
    endcase
  endfunction

  // One clock: model consumes the inputs present before the edge.
  task automatic cycle();
    logic [7:0] wd, rise, pin;
    logic       wr;
    wd   = writedata[7:0];
    wr   = chipselect & ~write_n;
    pin  = gpio_in;
    rise = hist[S-1] & ~hist[S];
    @(posedge clk);
    #1;
    if (wr) begin
      case (address)
        3'd0: m_out = wd;
        3'd1: m_dir = wd;
        3'd2: m_mask = wd;
        3'd3: m_cap = m_cap & ~wd;
        3'd4: m_out = m_out | wd;
        3'd5: m_out = m_out & ~wd;
        default: ;
      endcase
    end
    m_cap = m_cap | rise;
    for (int i = S; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pin;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cycle();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  initial begin
    logic [31:0] r;
    logic [2:0]  ra;
    m_reset();

    // Reset state and synchronised readback.
    gpio_in = 8'hA5;
    #12;
    chk("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
    chk("rst_gpio_oe", {24'h0, gpio_oe}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) cycle();
    rd(3'd0, r);
    chk("read_pins_a5", r, 32'h0000_00A5);

    // Mixed direction readback.
    gpio_in = 8'hF0;
    wr_reg(3'd1, 32'h0F);
    wr_reg(3'd0, 32'h3C);
    repeat (3) cycle();
    chk("data_gpio_out", {24'h0, gpio_out}, 32'h3C);
    chk("dir_gpio_oe", {24'h0, gpio_oe}, 32'h0F);
    rd(3'd0, r);
    chk("read_mixed_fc", r, 32'hFC);

    // Atomic set/clear.
    wr_reg(3'd0, 32'h81);
    wr_reg(3'd4, 32'hFFFF_FF06);
    chk("outset", {24'h0, gpio_out}, 32'h87);
    wr_reg(3'd5, 32'h81);
    chk("outclr", {24'h0, gpio_out}, 32'h06);
    rd(3'd4, r);
    chk("read_outset_zero", r, 32'h0);
    rd(3'd5, r);
    chk("read_outclr_zero", r, 32'h0);

    // Rising edge latency, irq, clear, and no capture on falling edge.
    gpio_in = 8'h00;
    repeat (4) cycle();
    wr_reg(3'd3, 32'hFF);
    wr_reg(3'd2, 32'h01);
    rd(3'd3, r);
    chk("cap_cleared", r, 32'h0);
    gpio_in = 8'h01;
    for (int k = 1; k <= S + 1; k++) begin
      cycle();
      rd(3'd3, r);
      chk($sformatf("edge_latency_%0d", k), r, (k == S + 1) ? 32'h1 : 32'h0);
    end
    chk("irq_set", {31'h0, irq}, 32'h1);
    wr_reg(3'd3, 32'h01);
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    gpio_in = 8'h00;
    repeat (4) cycle();
    rd(3'd3, r);
    chk("no_fall_capture", r, 32'h0);

    // Clear-write coinciding with a new edge on bit2: the edge wins.
    wr_reg(3'd2, 32'h05);
    gpio_in = 8'h05;
    repeat (S) cycle();
    wr_reg(3'd3, 32'h04);
    rd(3'd3, r);
    chk("set_beats_clear", r, 32'h05);
    chk("irq_held", {31'h0, irq}, 32'h1);
    chk("model_cap_agree", r, m_read(3'd3));

    // Narrow instance: load DIR/DATA so reset has something to undo.
    address = 3'd1; writedata = 32'hF; cs4 = 1'b1; write_n = 1'b0;
    cycle();
    address = 3'd0; writedata = 32'hA;
    cycle();
    cs4 = 1'b0; write_n = 1'b1;
    chk("w4_gpio_out", {28'h0, gpio_out4}, 32'hA);
    chk("w4_gpio_oe", {28'h0, gpio_oe4}, 32'hF);

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_irq", {31'h0, irq}, 32'h0);
    rd(3'd3, r);
    chk("async_cap", r, 32'h0);
    chk("async_gpio_out", {24'h0, gpio_out}, 32'h0);
    chk("async_w4_out", {28'h0, gpio_out4}, 32'h5);
    chk("async_w4_oe", {28'h0, gpio_oe4}, 32'h0);
    m_reset();
    gpio_in = 8'hFF;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= S + 1; k++) begin
      cycle();
      rd(3'd3, r);
      chk($sformatf("post_rst_edge_%0d", k), r, (k == S + 1) ? 32'hFF : 32'h0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
      cycle();
      chipselect = 1'b0; write_n = 1'b1;
      chk("rnd_gpio_out", {24'h0, gpio_out}, {24'h0, m_out});
      chk("rnd_gpio_oe", {24'h0, gpio_oe}, {24'h0, m_dir});
      chk("rnd_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
      ra = 3'($urandom_range(0, 7));
      rd(ra, r);
      chk($sformatf("rnd_read_a%0d", ra), r, m_read(ra));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
